// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with long-latency result buffer and busy scoreboard
// Optional feature: define LU_PASSTHRU_EN for zero-latency result pass-through when the write port is idle.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    output logic              lu_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_waddr,
    input  logic              id_re1,
    input  logic [ADDR_W-1:0] id_raddr1,
    input  logic              id_re2,
    input  logic [ADDR_W-1:0] id_raddr2,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int         NREG       = 1 << ADDR_W;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [3:0]        starve_cnt;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_set;
    logic [NREG-1:0]   busy_clr;

    logic              accept;
    logic              drain;
    logic              pass;
    logic              clr_valid;
    logic [ADDR_W-1:0] clr_addr;
    logic              haz1;
    logic              haz2;
    logic              waw;

    assign lu_ready = (state == EMPTY) && !rst;
    assign drain    = (state == FULL) && !wb_we && !rst;

`ifdef LU_PASSTHRU_EN
    assign pass = (state == EMPTY) && !wb_we && lu_valid && !rst;
`else
    assign pass = 1'b0;
`endif

    // A passed-through result never occupies the buffer.
    assign accept    = lu_valid && lu_ready && !pass;
    assign clr_valid = drain || pass;
    assign clr_addr  = drain ? buf_addr : lu_waddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (drain)  state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_we) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (drain) begin
            rf_we    = (buf_addr != '0);
            rf_waddr = buf_addr;
            rf_wdata = buf_data;
        end else if (pass) begin
            rf_we    = (lu_waddr != '0);
            rf_waddr = lu_waddr;
            rf_wdata = lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_addr <= '0;
            buf_data <= '0;
        end else if (accept) begin
            buf_addr <= lu_waddr;
            buf_data <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || drain) begin
            starve_cnt <= 4'd0;
        end else if ((state == FULL) && wb_we && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // A source being written this very cycle is no longer a hazard.
    assign haz1 = id_re1 && busy[id_raddr1] && !(clr_valid && (clr_addr == id_raddr1));
    assign haz2 = id_re2 && busy[id_raddr2] && !(clr_valid && (clr_addr == id_raddr2));
    assign waw  = iss_valid && busy[iss_waddr] && !(clr_valid && (clr_addr == iss_waddr));

    assign stall = !rst && (haz1 || haz2 || waw || (starve_cnt == STARVE_LIM));

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid && !stall && (iss_waddr != '0)) begin
            busy_set[iss_waddr] = 1'b1;
        end
        if (clr_valid) begin
            busy_clr[clr_addr] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~busy_clr) | busy_set) & ~{{(NREG-1){1'b0}}, 1'b1};
        end
    end

endmodule
